stim_player: RTL and testbench
==============================

Name: stim_player

Overview:
- Stimulus pattern generator; the drive-side counterpart of the on-chip logic-analyzer capture of the a/b/c test nets.
- A host loads a short pattern over a bit-serial load port, one word at a time, into a small pattern memory.
- On start, the block plays the pattern onto stim_out, one word per clk, once or looping.
- trig_out marks the start of each pass so the analyzer can trigger on it.

Parameters:
DATA_W, 3, width of one pattern word (bit0=a, bit1=b, bit2=c)
DEPTH, 16, pattern memory depth in words (power of two)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  the block's only clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
shift_en  input  1  shift shift_din into the load shift register this cycle
shift_din  input  1  serial load data, LSB of word first
update  input  1  pulse: commit shift register to mem[wr_ptr]
clear  input  1  pulse: empty the pattern (wr_ptr <= 0)
start  input  1  pulse: begin playback
stop  input  1  pulse: abort playback
loop_en  input  1  sampled at start; 1 = repeat pattern continuously
stim_out  output  DATA_W  registered stimulus word
trig_out  output  1  1-cycle pulse coincident with stim_out = mem[0]
busy  output  1  playback in progress
done  output  1  1-cycle pulse at end of a non-loop pass
count  output  ADDR_W+1  words loaded (0..DEPTH)
ovf  output  1  sticky: update attempted while count==DEPTH
load_err  output  1  sticky: update or clear attempted while busy

Behaviour:
- Reset: stim_out=0, trig_out=0, busy=0, done=0, count=0, ovf=0, load_err=0, shift register=0, state=IDLE. Memory contents are not reset.
- Reset applied mid-playback or mid-load aborts immediately; the next cycle shows reset values.
- Shift register: when shift_en=1, sr <= {shift_din, sr[DATA_W-1:1]}. After DATA_W shifts, the first bit is in sr[0]. Shifting is allowed in any state.
- update, in IDLE with count<DEPTH: mem[count] <= sr, count <= count+1, effective the next cycle.
  - count==DEPTH: the write is dropped and ovf is set.
  - busy: the write is dropped and load_err is set.
  - update and shift_en in the same cycle: the pre-shift sr is written.
- clear, in IDLE: count <= 0. While busy it is ignored and sets load_err. clear and update in the same cycle: clear wins.
- ovf and load_err clear only on rst or on clear accepted in IDLE.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 and count>0 → RUN, rd_ptr <= 0, loop latched from loop_en.
  - start with count==0 is ignored.
  - busy=0.
- RUN:
  - busy=1.
  - Each cycle: stim_out <= mem[rd_ptr]; trig_out <= (rd_ptr==0).
  - If rd_ptr==count-1: with loop, rd_ptr wraps to 0 with no gap cycle; otherwise → FIN. Else rd_ptr++.
  - start is ignored.
  - stop=1 → IDLE next cycle, with no further stim_out update and no done pulse.
  - stop has priority over the wrap and FIN transitions in the same cycle.
- FIN: done=1 for exactly one cycle, busy=0, then → IDLE.
- Timing, with start accepted in cycle T:
  - stim_out=mem[k] in cycle T+1+k for k=0..count-1; trig_out=1 in T+1.
  - Non-loop: done=1 in T+1+count, and busy is high in cycles T+1..T+count.
- stim_out holds its last value in IDLE and FIN. It changes only in RUN or on rst.
- Arithmetic: rd_ptr is ADDR_W bits; count is ADDR_W+1 bits so that DEPTH is representable. No wrap on count.

Test Plan:
- Load 3 words 3'b101, 3'b010, 3'b111 (3 shifts plus update each) → count=3. start, loop_en=0 → stim_out 5,2,7 in T+1..T+3; trig_out only at T+1; done at T+4; stim_out stays 7.
- Same pattern, loop_en=1 → stim_out 5,2,7,5,2,7… with no gaps, and trig_out every 3rd cycle. Pulse stop at T+5 → busy=0 at T+6, stim_out frozen at 2, no done.
- Load 16 words, then a 17th update → count=16, ovf=1, mem unchanged. clear → count=0, ovf=0.
- start with count=0 → busy stays 0, stim_out unchanged, no done.
- update and clear issued during RUN → ignored, load_err=1, and playback sequence unaltered.
- rst asserted at T+2 of an 8-word pass → next cycle all outputs 0 and state IDLE. A subsequent start with count=0 is ignored.

Source files
------------

// File: rtl/stim_player.sv
// Pattern stimulus player: serial-loaded word memory played onto stim_out,
// once or looping, with a trigger pulse at the start of every pass.
module stim_player #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              shift_din,
  input  logic              update,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [DATA_W-1:0] stim_out,
  output logic              trig_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              load_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   stim_q, stim_d;
  logic                trig_q, trig_d;
  logic                loop_q, loop_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                we;
  logic                running;
  logic                last;
  logic [ADDR_W-1:0]   rd_nx;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign running = (state_q == RUN);
  assign rd_nx   = rd_q + ADDR_W'(1);
  // rd_q is the index of the word currently on stim_out
  assign last    = ({1'b0, rd_q} == (count_q - CNT_W'(1)));

  always_comb begin
    sr_d    = sr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    we      = 1'b0;

    if (shift_en) begin
      sr_d = {shift_din, sr_q[DATA_W-1:1]};
    end

    if (clear) begin
      if (running) begin
        err_d = 1'b1;
      end else begin
        count_d = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end
    end else if (update) begin
      if (running) begin
        err_d = 1'b1;
      end else if (count_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        we      = 1'b1;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    stim_d  = stim_q;
    trig_d  = 1'b0;
    loop_d  = loop_q;

    unique case (state_q)
      IDLE: begin
        if (start && (count_q != '0)) begin
          state_d = RUN;
          rd_d    = '0;
          stim_d  = mem[0];
          trig_d  = 1'b1;
          loop_d  = loop_en;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (last) begin
          if (loop_q) begin
            rd_d   = '0;
            stim_d = mem[0];
            trig_d = 1'b1;
          end else begin
            state_d = FIN;
          end
        end else begin
          rd_d   = rd_nx;
          stim_d = mem[rd_nx];
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      count_q <= '0;
      rd_q    <= '0;
      stim_q  <= '0;
      trig_q  <= 1'b0;
      loop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      stim_q  <= stim_d;
      trig_q  <= trig_d;
      loop_q  <= loop_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[count_q[ADDR_W-1:0]] <= sr_q;
    end
  end

  assign stim_out = stim_q;
  assign trig_out = trig_q;
  assign busy     = running;
  assign done     = (state_q == FIN);
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_stim_player.sv
// Directed bench for stim_player: loading, one-shot and looped playback,
// overflow, load errors while busy and reset during playback.
module tb_stim_player;

  logic       clk = 1'b0;
  logic       rst, shift_en, shift_din, update, clear;
  logic       start, stop, loop_en;
  logic [2:0] stim_out;
  logic       trig_out, busy, done, ovf, load_err;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stim_player #(.DATA_W(3), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .shift_en(shift_en), .shift_din(shift_din),
    .update(update), .clear(clear),
    .start(start), .stop(stop), .loop_en(loop_en),
    .stim_out(stim_out), .trig_out(trig_out),
    .busy(busy), .done(done), .count(count),
    .ovf(ovf), .load_err(load_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [2:0] w);
    for (int i = 0; i < 3; i++) begin
      shift_en  = 1'b1;
      shift_din = w[i];
      step();
    end
    shift_en = 1'b0;
    update   = 1'b1;
    step();
    update = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if (stim_out !== 3'd0) begin n_bad++; $display("FAIL reset_stim: got %0d want 0", stim_out); end
    n_cmp++; if (trig_out !== 1'b0) begin n_bad++; $display("FAIL reset_trig: got %0b want 0", trig_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", load_err); end
  endtask

  task automatic test_oneshot();
    logic [2:0] exp [3];
    exp = '{3'd5, 3'd2, 3'd7};
    load_word(3'b101);
    load_word(3'b010);
    load_word(3'b111);
    n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL oneshot_count: got %0d want 3", count); end
    loop_en = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (stim_out !== exp[k]) begin n_bad++; $display("FAIL oneshot_stim k=%0d: got %0d want %0d", k, stim_out, exp[k]); end
      n_cmp++; if (trig_out !== (k == 0)) begin n_bad++; $display("FAIL oneshot_trig k=%0d: got %0b want %0b", k, trig_out, k == 0); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL oneshot_busy k=%0d: got %0b want 1", k, busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL oneshot_done_early k=%0d: got %0b want 0", k, done); end
      step();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL oneshot_done: got %0b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL oneshot_busy_fin: got %0b want 0", busy); end
    n_cmp++; if (stim_out !== 3'd7) begin n_bad++; $display("FAIL oneshot_hold: got %0d want 7", stim_out); end
    n_cmp++; if (trig_out !== 1'b0) begin n_bad++; $display("FAIL oneshot_trig_fin: got %0b want 0", trig_out); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL oneshot_done_pulse: got %0b want 0", done); end
    n_cmp++; if (stim_out !== 3'd7) begin n_bad++; $display("FAIL oneshot_hold_idle: got %0d want 7", stim_out); end
  endtask

  task automatic test_loop();
    logic [2:0] exp [5];
    exp = '{3'd5, 3'd2, 3'd7, 3'd5, 3'd2};
    loop_en = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    loop_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (stim_out !== exp[k]) begin n_bad++; $display("FAIL loop_stim k=%0d: got %0d want %0d", k, stim_out, exp[k]); end
      n_cmp++; if (trig_out !== (k == 0 || k == 3)) begin n_bad++; $display("FAIL loop_trig k=%0d: got %0b want %0b", k, trig_out, k == 0 || k == 3); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL loop_busy k=%0d: got %0b want 1", k, busy); end
      if (k < 4) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %0b want 0", busy); end
    n_cmp++; if (stim_out !== 3'd2) begin n_bad++; $display("FAIL stop_freeze: got %0d want 2", stim_out); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stop_done: got %0b want 0", done); end
    n_cmp++; if (trig_out !== 1'b0) begin n_bad++; $display("FAIL stop_trig: got %0b want 0", trig_out); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stop_done_late: got %0b want 0", done); end
    n_cmp++; if (stim_out !== 3'd2) begin n_bad++; $display("FAIL stop_freeze_late: got %0d want 2", stim_out); end
  endtask

  task automatic test_load_err();
    logic [2:0] exp [3];
    exp = '{3'd5, 3'd2, 3'd7};
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL lerr_pre: got %0b want 0", load_err); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (stim_out !== exp[k]) begin n_bad++; $display("FAIL lerr_stim k=%0d: got %0d want %0d", k, stim_out, exp[k]); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lerr_busy k=%0d: got %0b want 1", k, busy); end
      if (k >= 1) begin
        n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL lerr_flag k=%0d: got %0b want 1", k, load_err); end
      end
      update = (k == 0);
      clear  = (k == 1);
      step();
    end
    update = 1'b0;
    clear  = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL lerr_done: got %0b want 1", done); end
    n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL lerr_count: got %0d want 3", count); end
    n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL lerr_sticky: got %0b want 1", load_err); end
    step();
  endtask

  task automatic test_start_empty();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL clr_count: got %0d want 0", count); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL clr_err: got %0b want 0", load_err); end
    start   = 1'b1;
    loop_en = 1'b1;
    step();
    start   = 1'b0;
    loop_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy k=%0d: got %0b want 0", k, busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL empty_done k=%0d: got %0b want 0", k, done); end
      n_cmp++; if (stim_out !== 3'd7) begin n_bad++; $display("FAIL empty_stim k=%0d: got %0d want 7", k, stim_out); end
      n_cmp++; if (trig_out !== 1'b0) begin n_bad++; $display("FAIL empty_trig k=%0d: got %0b want 0", k, trig_out); end
      step();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) load_word(3'((i * 3 + 1) % 8));
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL full_count: got %0d want 16", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL full_ovf: got %0b want 0", ovf); end
    load_word(3'b110);
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_count: got %0d want 16", count); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL ovf_err: got %0b want 0", load_err); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (stim_out !== 3'((k * 3 + 1) % 8)) begin n_bad++; $display("FAIL full_stim k=%0d: got %0d want %0d", k, stim_out, (k * 3 + 1) % 8); end
      n_cmp++; if (trig_out !== (k == 0)) begin n_bad++; $display("FAIL full_trig k=%0d: got %0b want %0b", k, trig_out, k == 0); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy k=%0d: got %0b want 1", k, busy); end
      step();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %0b want 1", done); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL ovf_clr_count: got %0d want 0", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_flag: got %0b want 0", ovf); end
  endtask

  task automatic test_pre_shift();
    logic [2:0] w;
    w = 3'b011;
    for (int i = 0; i < 3; i++) begin
      shift_en  = 1'b1;
      shift_din = w[i];
      step();
    end
    shift_din = 1'b1;
    update    = 1'b1;
    step();
    update   = 1'b0;
    shift_en = 1'b0;
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL pre_count: got %0d want 1", count); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (stim_out !== 3'd3) begin n_bad++; $display("FAIL pre_stim: got %0d want 3", stim_out); end
    n_cmp++; if (trig_out !== 1'b1) begin n_bad++; $display("FAIL pre_trig: got %0b want 1", trig_out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_busy: got %0b want 1", busy); end
    step();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL pre_done: got %0b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pre_busy_fin: got %0b want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 8; i++) load_word(3'((i + 2) % 8));
    n_cmp++; if (count !== 5'd8) begin n_bad++; $display("FAIL mid_count: got %0d want 8", count); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (stim_out !== 3'd2) begin n_bad++; $display("FAIL mid_stim0: got %0d want 2", stim_out); end
    step();
    n_cmp++; if (stim_out !== 3'd3) begin n_bad++; $display("FAIL mid_stim1: got %0d want 3", stim_out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (stim_out !== 3'd0) begin n_bad++; $display("FAIL mid_rst_stim: got %0d want 0", stim_out); end
    n_cmp++; if (trig_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_trig: got %0b want 0", trig_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %0b want 0", done); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", count); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_start_busy: got %0b want 0", busy); end
    n_cmp++; if (stim_out !== 3'd0) begin n_bad++; $display("FAIL mid_start_stim: got %0d want 0", stim_out); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_start_done: got %0b want 0", done); end
  endtask

  initial begin
    rst       = 1'b1;
    shift_en  = 1'b0;
    shift_din = 1'b0;
    update    = 1'b0;
    clear     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    test_reset();
    test_oneshot();
    test_loop();
    test_load_err();
    test_start_empty();
    test_overflow();
    test_pre_shift();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
